// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan sequencer and its environment: scan control
// inputs, the mux select/enable it drives, the sampled mux output it reads
// back, and the scan status/result.
interface mux_scan_ctrl_if #(
  parameter int unsigned NUM_CH  = 7,
  parameter int unsigned DWELL_W = 4
);
  logic               start_in;
  logic               stop_in;
  logic               cont_in;
  logic [NUM_CH-1:0]  ch_mask_in;
  logic [DWELL_W-1:0] dwell_in;
  logic               mux_sample_in;
  logic [2:0]         sel_out;
  logic               en_out;
  logic               busy_out;
  logic               done_out;
  logic [NUM_CH-1:0]  result_out;

  modport master (
    output start_in, stop_in, cont_in, ch_mask_in, dwell_in, mux_sample_in,
    input  sel_out, en_out, busy_out, done_out, result_out
  );

  modport slave (
    input  start_in, stop_in, cont_in, ch_mask_in, dwell_in, mux_sample_in,
    output sel_out, en_out, busy_out, done_out, result_out
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 7:1 mux stage. Steps sel/en through the enabled
// channels, waits dwell+1 settle cycles on each, samples the mux output for
// one cycle and assembles one result bit per channel.
module mux_scan_ctrl #(
  parameter int unsigned NUM_CH  = 7,
  parameter int unsigned DWELL_W = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  mux_scan_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ch_q, ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0]  result_q, result_d;
  logic               done_q, done_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;

  logic [NUM_CH-1:0]  merged;
  logic [3:0]         found;

  // Lowest set mask bit at index >= lo; returns {valid, index}.
  function automatic logic [3:0] find_set(input logic [NUM_CH-1:0] m,
                                          input logic [3:0]        lo);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (m[i-1] && (4'(i - 1) >= lo)) r = {1'b1, 3'(i - 1)};
    end
    return r;
  endfunction

  // Shadow result with the bit of the channel currently being sampled.
  always_comb begin
    merged = shadow_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (3'(i) == ch_q) merged[i] = bus.mux_sample_in;
    end
  end

  // Next-state and datapath updates; stop_in overrides everything while busy.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    result_d = result_q;
    done_d   = 1'b0;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    cont_d   = cont_q;
    found    = '0;
    case (state_q)
      IDLE: begin
        if (bus.start_in && !bus.stop_in) begin
          if (bus.ch_mask_in != '0) begin
            found    = find_set(bus.ch_mask_in, 4'd0);
            mask_d   = bus.ch_mask_in;
            dwell_d  = bus.dwell_in;
            cont_d   = bus.cont_in;
            shadow_d = '0;
            ch_d     = found[2:0];
            cnt_d    = bus.dwell_in;
            state_d  = SETTLE;
          end else begin
            result_d = '0;
            done_d   = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (bus.stop_in)       state_d = IDLE;
        else if (cnt_q == '0)  state_d = SAMPLE;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        if (bus.stop_in) begin
          state_d = IDLE;
        end else begin
          shadow_d = merged;
          found    = find_set(mask_q, {1'b0, ch_q} + 4'd1);
          if (found[3]) begin
            ch_d    = found[2:0];
            cnt_d   = dwell_q;
            state_d = SETTLE;
          end else begin
            result_d = merged;
            done_d   = 1'b1;
            if (cont_q) begin
              found    = find_set(mask_q, 4'd0);
              shadow_d = '0;
              ch_d     = found[2:0];
              cnt_d    = dwell_q;
              state_d  = SETTLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      mask_q   <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      cont_q   <= cont_d;
    end
  end

  // Select parks at 3'b111 whenever the mux is disabled.
  assign bus.sel_out    = (state_q == IDLE) ? 3'b111 : ch_q;
  assign bus.en_out     = (state_q != IDLE);
  assign bus.busy_out   = (state_q != IDLE);
  assign bus.done_out   = done_q;
  assign bus.result_out = result_q;

endmodule
